bti_ram_slv: RTL and testbench

- BTI responder: terminates a BTI request channel (slave end) and returns one response per accepted request on a BTI response channel.
- Backed by an internal single-port, byte-strobed synchronous RAM.
- Serves as the instruction/data memory behind the core's BTI initiators in simulation and FPGA builds.
- Response path is buffered, so response back-pressure never stalls the RAM pipeline; requests are throttled by credit instead.

---
 rtl/bti_pkg.sv | 42 ++++
 rtl/bti_if.sv | 23 ++
 rtl/bti_rsp_fifo.sv | 67 ++++++
 rtl/bti_ram_slv.sv | 121 ++++++++++++
 tb/tb_bti_ram_slv.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bti_pkg.sv
// Shared BTI definitions: command encodings, request/response packets and
// the byte-address to word-index helper used by BTI responders.
`ifndef BTI_TIDW
`define BTI_TIDW 4
`endif

package bti_pkg;

    localparam int BTI_TIDW   = `BTI_TIDW;
    localparam int BTI_PKT_AW = 32;
    localparam int BTI_PKT_DW = 32;
    localparam int BTI_PKT_SW = BTI_PKT_DW / 8;

    // Two-bit field so that encodings 2 and 3 exist and can be rejected.
    typedef enum logic [1:0] {
        BTI_CMD_READ  = 2'd0,
        BTI_CMD_WRITE = 2'd1
    } bti_cmd_t;

    typedef struct packed {
        logic [BTI_TIDW-1:0]   tid;
        bti_cmd_t              cmd;
        logic [BTI_PKT_AW-1:0] addr;
        logic [BTI_PKT_DW-1:0] data;
        logic [BTI_PKT_SW-1:0] strobe;
    } bti_req_pkt_t;

    typedef struct packed {
        logic [BTI_TIDW-1:0]   tid;
        logic [BTI_PKT_DW-1:0] data;
        logic                  ok;
    } bti_rsp_pkt_t;

    // Drop the byte-offset bits of a byte address to get a word index.
    function automatic logic [BTI_PKT_AW-1:0] bti_word_index(
        input logic [BTI_PKT_AW-1:0] addr,
        input int unsigned           off_bits
    );
        return addr >> off_bits;
    endfunction

endpackage

// File: rtl/bti_if.sv
// BTI request and response channel interfaces. The master drives vld/pkt,
// the slave drives rdy; a transfer happens on a clock edge with vld && rdy.
interface bti_req_if_t;
    import bti_pkg::*;

    logic         vld;
    logic         rdy;
    bti_req_pkt_t pkt;

    modport mst (output vld, output pkt, input rdy);
    modport slv (input vld, input pkt, output rdy);
endinterface

interface bti_rsp_if_t;
    import bti_pkg::*;

    logic         vld;
    logic         rdy;
    bti_rsp_pkt_t pkt;

    modport mst (output vld, output pkt, input rdy);
    modport slv (input vld, input pkt, output rdy);
endinterface

// File: rtl/bti_rsp_fifo.sv
// Synchronous FIFO of BTI response packets. The head entry is presented
// combinationally and forced to zero while empty so the channel never shows
// stale data. Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module bti_rsp_fifo
    import bti_pkg::*;
#(
    parameter  int DEPTH = 3,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  bti_rsp_pkt_t  push_pkt,
    input  logic          pop,
    output bti_rsp_pkt_t  head_pkt,
    output logic          empty,
    output logic [CW-1:0] count
);

    bti_rsp_pkt_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;
    logic          full;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop   = pop && !empty;
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign head_pkt = empty ? '0 : mem[rd_ptr];

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_pkt;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The upstream credit scheme must never let a push land on a full FIFO.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/bti_ram_slv.sv
// BTI RAM responder. Stage 0 accepts a request and performs the RAM access,
// stage 1 forms the response and pushes it into a small FIFO that feeds the
// response channel. Requests are throttled by credit (FIFO occupancy plus the
// one in-flight slot) so response back-pressure never stalls the RAM pipe.
module bti_ram_slv
    import bti_pkg::*;
#(
    parameter int    BTI_AW    = BTI_PKT_AW,
    parameter int    BTI_DW    = BTI_PKT_DW,
    parameter int    MEM_DEPTH = 1024,
    parameter int    RSP_DEPTH = 3,
    parameter string INIT_FILE = ""
) (
    input logic      clk,
    input logic      rst,
    bti_req_if_t.slv req,
    bti_rsp_if_t.mst rsp
);

    localparam int OFF_BITS = $clog2(BTI_DW / 8);
    localparam int SW       = BTI_DW / 8;
    localparam int RAM_AW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CW       = $clog2(RSP_DEPTH + 1);

    logic [BTI_DW-1:0]   ram [MEM_DEPTH];

    logic [BTI_AW-1:0]   word_idx;
    logic [RAM_AW-1:0]   ram_addr;
    logic                in_range;
    logic                cmd_read;
    logic                cmd_write;
    logic                req_rdy;
    logic                req_fire;
    logic                do_write;
    logic                do_read;

    logic                inflight;
    logic [BTI_TIDW-1:0] s1_tid;
    logic                s1_ok;
    logic                s1_rd_sel;
    logic [BTI_DW-1:0]   s1_rd_data;

    bti_rsp_pkt_t        fifo_pkt;
    bti_rsp_pkt_t        fifo_head;
    logic                fifo_empty;
    logic                fifo_pop;
    logic [CW-1:0]       fifo_cnt;
    logic [CW:0]         credit_used;

    // Decode: word index drops byte-offset bits; only in-range words touch RAM.
    assign word_idx  = bti_word_index(req.pkt.addr, OFF_BITS);
    assign ram_addr  = word_idx[RAM_AW-1:0];
    assign in_range  = (word_idx < BTI_AW'(MEM_DEPTH));
    assign cmd_read  = (req.pkt.cmd == BTI_CMD_READ);
    assign cmd_write = (req.pkt.cmd == BTI_CMD_WRITE);

    // Credit check uses registered state only, never the response ready.
    assign credit_used = {1'b0, fifo_cnt} + {{CW{1'b0}}, inflight};
    assign req_rdy     = !rst && (credit_used < (CW + 1)'(RSP_DEPTH));
    assign req.rdy     = req_rdy;
    assign req_fire    = req.vld && req_rdy;
    assign do_write    = req_fire && cmd_write && in_range;
    assign do_read     = req_fire && cmd_read && in_range;

    // Stage 0 RAM port: byte-strobed write and registered read of the same word.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < SW; i++) begin
                if (req.pkt.strobe[i]) begin
                    ram[ram_addr][i*8 +: 8] <= req.pkt.data[i*8 +: 8];
                end
            end
        end
        if (do_read) begin
            s1_rd_data <= ram[ram_addr];
        end
    end

    // Stage 1 bookkeeping: capture what the response needs from the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight  <= 1'b0;
            s1_tid    <= '0;
            s1_ok     <= 1'b0;
            s1_rd_sel <= 1'b0;
        end else begin
            inflight <= req_fire;
            if (req_fire) begin
                s1_tid    <= req.pkt.tid;
                s1_ok     <= in_range && (cmd_read || cmd_write);
                s1_rd_sel <= cmd_read && in_range;
            end
        end
    end

    // Response packet: data only for in-range reads, zero otherwise.
    always_comb begin
        fifo_pkt      = '0;
        fifo_pkt.tid  = s1_tid;
        fifo_pkt.ok   = s1_ok;
        fifo_pkt.data = s1_rd_sel ? s1_rd_data : '0;
    end

    assign fifo_pop = !fifo_empty && rsp.rdy;
    assign rsp.vld  = !fifo_empty;
    assign rsp.pkt  = fifo_head;

    bti_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_pkt (fifo_pkt),
        .pop      (fifo_pop),
        .head_pkt (fifo_head),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

endmodule

// File: tb/tb_bti_ram_slv.sv
// Self-checking bench for bti_ram_slv: a vector table of requests with their
// expected responses feeds a scoreboard queue; a monitor compares every
// response taken from the DUT against the queue head, in order.
module tb_bti_ram_slv;
    import bti_pkg::*;

    logic clk = 1'b0;
    logic rst;

    bti_req_if_t req_if();
    bti_rsp_if_t rsp_if();

    bti_ram_slv #(
        .BTI_AW    (32),
        .BTI_DW    (32),
        .MEM_DEPTH (1024),
        .RSP_DEPTH (3),
        .INIT_FILE ("")
    ) dut (
        .clk (clk),
        .rst (rst),
        .req (req_if),
        .rsp (rsp_if)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int rsp_seen     = 0;
    int stall_count  = 0;
    int rsp_cycle [int];
    bti_rsp_pkt_t exp_q [$];

    typedef struct {
        bti_cmd_t    cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strobe;
        logic [3:0]  tid;
        logic        exp_ok;
        logic [31:0] exp_data;
    } vec_t;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
        end
    endtask

    // Response monitor: every response taken must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_if.vld && rsp_if.rdy) begin
            rsp_cycle[rsp_seen] = cyc;
            rsp_seen++;
            if (exp_q.size() == 0) begin
                checkOutput("rsp_unexpected", 64'(rsp_if.pkt), 64'd0);
            end else begin
                checkOutput("rsp_pkt", 64'(rsp_if.pkt), 64'(exp_q.pop_front()));
            end
        end
    end

    function automatic vec_t mkVec(input bti_cmd_t cmd, input logic [31:0] addr, input logic [31:0] data,
                                   input logic [3:0] strobe, input logic [3:0] tid, input logic exp_ok,
                                   input logic [31:0] exp_data);
        vec_t v;
        v.cmd = cmd; v.addr = addr; v.data = data; v.strobe = strobe;
        v.tid = tid; v.exp_ok = exp_ok; v.exp_data = exp_data;
        return v;
    endfunction

    // Present one request (called just after a rising edge) and hold it until accepted.
    task automatic applyStimulus(input bti_cmd_t cmd, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strobe, input logic [3:0] tid, input logic exp_ok,
                                 input logic [31:0] exp_data, output int acc_cyc);
        bti_rsp_pkt_t e;
        logic accepted = 1'b0;
        acc_cyc = -1;
        req_if.vld        = 1'b1;
        req_if.pkt.cmd    = cmd;
        req_if.pkt.addr   = addr;
        req_if.pkt.data   = data;
        req_if.pkt.strobe = strobe;
        req_if.pkt.tid    = tid;
        for (int w = 0; w < 100; w++) begin
            @(negedge clk);
            if (req_if.rdy) begin
                e.tid = tid; e.data = exp_data; e.ok = exp_ok;
                exp_q.push_back(e);
                acc_cyc  = cyc;
                accepted = 1'b1;
            end else begin
                stall_count++;
            end
            @(posedge clk);
            #1;
            if (accepted) break;
        end
        if (!accepted) begin
            checkOutput("req_accept_timeout", 64'd0, 64'd1);
            req_if.vld = 1'b0;
        end
    endtask

    task automatic drain();
        req_if.vld = 1'b0;
        for (int w = 0; w < 200 && exp_q.size() != 0; w++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: actual no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [14];
        int acc;
        int base;
        int accepted;

        vecs[0]  = mkVec(BTI_CMD_WRITE, 32'h10,   32'hDEADBEEF, 4'hF, 4'd1,  1'b1, 32'h0);
        vecs[1]  = mkVec(BTI_CMD_READ,  32'h10,   32'h0,        4'h0, 4'd2,  1'b1, 32'hDEADBEEF);
        vecs[2]  = mkVec(BTI_CMD_WRITE, 32'h20,   32'h11223344, 4'hF, 4'd3,  1'b1, 32'h0);
        vecs[3]  = mkVec(BTI_CMD_WRITE, 32'h20,   32'hAABBCCDD, 4'h5, 4'd4,  1'b1, 32'h0);
        vecs[4]  = mkVec(BTI_CMD_READ,  32'h20,   32'h0,        4'h0, 4'd5,  1'b1, 32'h11BB33DD);
        vecs[5]  = mkVec(BTI_CMD_WRITE, 32'h0,    32'hCAFEF00D, 4'hF, 4'd6,  1'b1, 32'h0);
        vecs[6]  = mkVec(BTI_CMD_WRITE, 32'h1000, 32'h12345678, 4'hF, 4'd7,  1'b0, 32'h0);
        vecs[7]  = mkVec(BTI_CMD_READ,  32'h1000, 32'h0,        4'h0, 4'd8,  1'b0, 32'h0);
        vecs[8]  = mkVec(BTI_CMD_READ,  32'h0,    32'h0,        4'h0, 4'd9,  1'b1, 32'hCAFEF00D);
        vecs[9]  = mkVec(BTI_CMD_READ,  32'h13,   32'h0,        4'h0, 4'd10, 1'b1, 32'hDEADBEEF);
        vecs[10] = mkVec(bti_cmd_t'(2'd3), 32'h10, 32'hFFFFFFFF, 4'hF, 4'd11, 1'b0, 32'h0);
        vecs[11] = mkVec(BTI_CMD_READ,  32'h10,   32'h0,        4'h0, 4'd12, 1'b1, 32'hDEADBEEF);
        vecs[12] = mkVec(BTI_CMD_WRITE, 32'hFFC,  32'h0BADC0DE, 4'hF, 4'd13, 1'b1, 32'h0);
        vecs[13] = mkVec(BTI_CMD_READ,  32'hFFC,  32'h0,        4'h0, 4'd14, 1'b1, 32'h0BADC0DE);

        rst        = 1'b1;
        req_if.vld = 1'b0;
        req_if.pkt = '0;
        rsp_if.rdy = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req_rdy_low", 64'(req_if.rdy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_rsp_vld", 64'(rsp_if.vld), 64'd0);
        checkOutput("reset_rsp_pkt", 64'(rsp_if.pkt), 64'd0);
        checkOutput("reset_req_rdy_after", 64'(req_if.rdy), 64'd1);
        @(posedge clk);
        #1;

        // Vector table, back to back with the response channel always ready
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].cmd, vecs[i].addr, vecs[i].data, vecs[i].strobe,
                          vecs[i].tid, vecs[i].exp_ok, vecs[i].exp_data, acc);
        end
        drain();

        // Minimum latency from accept to rsp.vld
        applyStimulus(BTI_CMD_READ, 32'h20, 32'h0, 4'h0, 4'd15, 1'b1, 32'h11BB33DD, acc);
        req_if.vld = 1'b0;
        begin
            int seen_at = -1;
            for (int w = 0; w < 10; w++) begin
                @(negedge clk);
                if (rsp_if.vld) begin
                    seen_at = cyc;
                    break;
                end
            end
            checkOutput("latency_cycles", 64'(seen_at - acc), 64'd2);
        end
        drain();

        // Back-pressure: only RSP_DEPTH requests get in while rsp.rdy is low
        base       = rsp_seen;
        accepted   = 0;
        rsp_if.rdy = 1'b0;
        req_if.vld        = 1'b1;
        req_if.pkt.cmd    = BTI_CMD_READ;
        req_if.pkt.addr   = 32'h10;
        req_if.pkt.data   = '0;
        req_if.pkt.strobe = '0;
        req_if.pkt.tid    = 4'd0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (req_if.rdy) begin
                bti_rsp_pkt_t e;
                e.tid = 4'(accepted); e.data = 32'hDEADBEEF; e.ok = 1'b1;
                exp_q.push_back(e);
                accepted++;
            end
            @(posedge clk);
            #1;
            req_if.pkt.tid = 4'(accepted);
        end
        checkOutput("bp_accepted", 64'(accepted), 64'd3);
        @(negedge clk);
        checkOutput("bp_req_rdy", 64'(req_if.rdy), 64'd0);
        checkOutput("bp_rsp_vld_held", 64'(rsp_if.vld), 64'd1);
        checkOutput("bp_head_tid", 64'(rsp_if.pkt.tid), 64'd0);
        @(posedge clk);
        #1;
        rsp_if.rdy = 1'b1;
        applyStimulus(BTI_CMD_READ, 32'h10, 32'h0, 4'h0, 4'd3, 1'b1, 32'hDEADBEEF, acc);
        applyStimulus(BTI_CMD_READ, 32'h10, 32'h0, 4'h0, 4'd4, 1'b1, 32'hDEADBEEF, acc);
        drain();
        checkOutput("bp_rsp_count", 64'(rsp_seen - base), 64'd5);

        // Full throughput: 16 writes then 16 reads with no stalls
        base        = rsp_seen;
        stall_count = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(BTI_CMD_WRITE, 32'h100 + 32'(4 * i), 32'hA5000000 ^ (32'h01010101 * 32'(i)),
                          4'hF, 4'(i), 1'b1, 32'h0, acc);
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(BTI_CMD_READ, 32'h100 + 32'(4 * i), 32'h0, 4'h0, 4'(i), 1'b1,
                          32'hA5000000 ^ (32'h01010101 * 32'(i)), acc);
        end
        drain();
        checkOutput("tp_stalls", 64'(stall_count), 64'd0);
        checkOutput("tp_rsp_count", 64'(rsp_seen - base), 64'd32);
        if (rsp_seen - base == 32) begin
            checkOutput("tp_consecutive_rsp", 64'(rsp_cycle[base + 31] - rsp_cycle[base + 16]), 64'd15);
        end

        // Reset mid-stream: buffered and in-flight responses vanish, writes stay
        rsp_if.rdy = 1'b0;
        applyStimulus(BTI_CMD_WRITE, 32'h30, 32'h5A5A1234, 4'hF, 4'd1, 1'b1, 32'h0, acc);
        applyStimulus(BTI_CMD_READ,  32'h10, 32'h0,       4'h0, 4'd2, 1'b1, 32'hDEADBEEF, acc);
        applyStimulus(BTI_CMD_READ,  32'h20, 32'h0,       4'h0, 4'd3, 1'b1, 32'h11BB33DD, acc);
        req_if.vld = 1'b0;
        rst        = 1'b1;
        exp_q.delete();
        base = rsp_seen;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        rsp_if.rdy = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_rsp_vld", 64'(rsp_if.vld), 64'd0);
        checkOutput("rst_mid_req_rdy", 64'(req_if.rdy), 64'd1);
        repeat (6) @(negedge clk);
        checkOutput("rst_mid_no_rsp", 64'(rsp_seen - base), 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(BTI_CMD_READ, 32'h30, 32'h0, 4'h0, 4'd4, 1'b1, 32'h5A5A1234, acc);
        applyStimulus(BTI_CMD_READ, 32'h10, 32'h0, 4'h0, 4'd5, 1'b1, 32'hDEADBEEF, acc);
        drain();
        checkOutput("rst_mid_post_rsp_count", 64'(rsp_seen - base), 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
